// File: rtl/parity_engine.sv
// Multi-cycle UART parity generator: folds BITS_PER_CYCLE frame bits per clock.
// Optional RX parity checking is built when PARITY_ENGINE_CHECK_EN is defined.
module parity_engine #(
    parameter int DATA_WIDTH     = 8,
    parameter int BITS_PER_CYCLE = 2,
    parameter int LEN_W          = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic [LEN_W-1:0]      data_len,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic                  Data_valid,
`ifdef PARITY_ENGINE_CHECK_EN
    input  logic                  rx_par_bit,
    output logic                  par_err,
`endif
    output logic                  ready,
    output logic                  par_bit,
    output logic                  par_valid
);

    // Handshake: a request transfers on a rising edge where Data_valid && ready;
    // ready is high in IDLE and DONE, so DONE can accept the next frame directly.

    localparam int IDX_W = $clog2(DATA_WIDTH + BITS_PER_CYCLE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] data_q;
    logic [LEN_W-1:0]      len_q;
    logic                  en_q;
    logic [1:0]            typ_q;
    logic                  acc;
    logic [IDX_W-1:0]      idx;

    logic [LEN_W-1:0]      len_eff;
    logic [DATA_WIDTH-1:0] len_mask;
    logic                  chunk;
    logic                  acc_next;
    logic                  last_fold;
    logic                  accept;
    logic                  par_next;

    function automatic logic par_calc(input logic en, input logic [1:0] typ, input logic a);
        logic p;
        p = 1'b0;
        if (en) begin
            case (typ)
                2'b00:   p = a;
                2'b01:   p = ~a;
                2'b10:   p = 1'b1;
                default: p = 1'b0;
            endcase
        end
        return p;
    endfunction

    // Clamp the requested length into 5..DATA_WIDTH and mask bits above it.
    always_comb begin
        len_eff = data_len;
        if (data_len > LEN_W'(DATA_WIDTH)) begin
            len_eff = LEN_W'(DATA_WIDTH);
        end else if (data_len < LEN_W'(5)) begin
            len_eff = LEN_W'(5);
        end
        len_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            len_mask[i] = (i < int'(len_eff));
        end
    end

    always_comb begin
        chunk = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if ((i >= int'(idx)) && (i < int'(idx) + BITS_PER_CYCLE)) begin
                chunk = chunk ^ data_q[i];
            end
        end
        acc_next  = acc ^ chunk;
        last_fold = (idx + IDX_W'(BITS_PER_CYCLE)) >= IDX_W'(len_q);
        par_next  = par_calc(en_q, typ_q, acc_next);
    end

    assign ready     = (state != CALC);
    assign par_valid = (state == DONE);
    assign accept    = Data_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_fold) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = accept ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            len_q   <= '0;
            en_q    <= 1'b0;
            typ_q   <= 2'b00;
            acc     <= 1'b0;
            idx     <= '0;
            par_bit <= 1'b0;
        end else if (accept) begin
            data_q <= P_DATA & len_mask;
            len_q  <= len_eff;
            en_q   <= PAR_EN;
            typ_q  <= PAR_TYP;
            acc    <= 1'b0;
            idx    <= '0;
        end else if (state == CALC) begin
            acc <= acc_next;
            idx <= idx + IDX_W'(BITS_PER_CYCLE);
            if (last_fold) begin
                par_bit <= par_next;
            end
        end
    end

`ifdef PARITY_ENGINE_CHECK_EN
    logic rx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q    <= 1'b0;
            par_err <= 1'b0;
        end else if (accept) begin
            rx_q <= rx_par_bit;
        end else if ((state == CALC) && last_fold) begin
            par_err <= en_q && (par_next != rx_q);
        end
    end
`endif

endmodule

// File: tb/tb_parity_engine.sv
// Directed bench for parity_engine: results, latency, masking, clamping, modes,
// mid-computation reset, busy-request rejection and back-to-back frames.
module tb_parity_engine;

    logic       clk;
    logic       rst;
    logic [7:0] P_DATA;
    logic [3:0] data_len;
    logic       PAR_EN;
    logic [1:0] PAR_TYP;
    logic       Data_valid;
    logic       ready;
    logic       par_bit;
    logic       par_valid;
`ifdef PARITY_ENGINE_CHECK_EN
    logic       rx_par_bit;
    logic       par_err;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    parity_engine #(
        .DATA_WIDTH    (8),
        .BITS_PER_CYCLE(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .P_DATA    (P_DATA),
        .data_len  (data_len),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Data_valid(Data_valid),
`ifdef PARITY_ENGINE_CHECK_EN
        .rx_par_bit(rx_par_bit),
        .par_err   (par_err),
`endif
        .ready     (ready),
        .par_bit   (par_bit),
        .par_valid (par_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send one frame, scramble inputs after acceptance, then measure latency and result.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [3:0] len,
                             input logic en, input logic [1:0] typ,
                             input logic exp_par, input int exp_lat);
        int cnt;
        int low;
        @(negedge clk);
        check({tag, "_ready_idle"}, 32'(ready), 32'd1);
        P_DATA = d; data_len = len; PAR_EN = en; PAR_TYP = typ; Data_valid = 1'b1;
        @(negedge clk);
        Data_valid = 1'b0;
        P_DATA     = 8'($urandom_range(0, 255));
        data_len   = 4'($urandom_range(0, 15));
        PAR_EN     = 1'($urandom_range(0, 1));
        PAR_TYP    = 2'($urandom_range(0, 3));
        cnt = 0;
        low = 0;
        while (!par_valid && cnt < 20) begin
            if (!ready) low++;
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(low), 32'(exp_lat));
        check({tag, "_par_bit"}, 32'(par_bit), 32'(exp_par));
        check({tag, "_ready_done"}, 32'(ready), 32'd1);
        @(negedge clk);
        check({tag, "_strobe_width"}, 32'(par_valid), 32'd0);
        check({tag, "_par_hold"}, 32'(par_bit), 32'(exp_par));
    endtask

    initial begin
        logic [7:0] words [3];
        logic       exp_b [3];
        int         cnt;
        int         strobes;
        int         last_cyc;
        logic       seen_par;

        rst = 1'b1; P_DATA = '0; data_len = 4'd8; PAR_EN = 1'b0; PAR_TYP = 2'b00;
        Data_valid = 1'b0;
`ifdef PARITY_ENGINE_CHECK_EN
        rx_par_bit = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_par_bit", 32'(par_bit), 32'd0);
        check("reset_par_valid", 32'(par_valid), 32'd0);
        rst = 1'b0;

        run_frame("even_a5", 8'hA5, 4'd8, 1'b1, 2'b00, 1'b0, 4);
        run_frame("odd_a5", 8'hA5, 4'd8, 1'b1, 2'b01, 1'b1, 4);
        run_frame("mask_len7", 8'h80, 4'd7, 1'b1, 2'b00, 1'b0, 4);
        run_frame("mask_len8", 8'h80, 4'd8, 1'b1, 2'b00, 1'b1, 4);
        run_frame("clamp_len3", 8'h30, 4'd3, 1'b1, 2'b00, 1'b1, 3);
        run_frame("clamp_len12", 8'h01, 4'd12, 1'b1, 2'b00, 1'b1, 4);
        run_frame("mark", 8'h00, 4'd8, 1'b1, 2'b10, 1'b1, 4);

        // Reset two cycles into a computation: abort, no strobe afterwards.
        @(negedge clk);
        P_DATA = 8'hA5; data_len = 4'd8; PAR_EN = 1'b1; PAR_TYP = 2'b01; Data_valid = 1'b1;
        @(negedge clk);
        Data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_ready", 32'(ready), 32'd1);
        check("midreset_par_bit", 32'(par_bit), 32'd0);
        check("midreset_par_valid", 32'(par_valid), 32'd0);
        rst = 1'b0;
        strobes = 0;
        repeat (10) begin
            @(negedge clk);
            if (par_valid) strobes++;
        end
        check("midreset_no_strobe", 32'(strobes), 32'd0);

        run_frame("space", 8'h01, 4'd8, 1'b1, 2'b11, 1'b0, 4);
        run_frame("disabled", 8'hFF, 4'd8, 1'b0, 2'b01, 1'b0, 4);

        // A request pulse while busy must be dropped.
        @(negedge clk);
        P_DATA = 8'h03; data_len = 4'd8; PAR_EN = 1'b1; PAR_TYP = 2'b00; Data_valid = 1'b1;
        @(negedge clk);
        Data_valid = 1'b0;
        @(negedge clk);
        P_DATA = 8'h01; Data_valid = 1'b1;
        @(negedge clk);
        Data_valid = 1'b0;
        strobes  = 0;
        seen_par = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (par_valid) begin
                strobes++;
                seen_par = par_bit;
            end
        end
        check("busy_pulse_strobes", 32'(strobes), 32'd1);
        check("busy_pulse_par_bit", 32'(seen_par), 32'd0);

        // Back-to-back with Data_valid held high.
        words[0] = 8'h01; words[1] = 8'h03; words[2] = 8'h07;
        exp_b[0] = 1'b1;  exp_b[1] = 1'b0;  exp_b[2] = 1'b1;
        last_cyc = 0;
        @(negedge clk);
        P_DATA = words[0]; data_len = 4'd8; PAR_EN = 1'b1; PAR_TYP = 2'b00; Data_valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            cnt = 0;
            @(negedge clk);
            while (!par_valid && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            check($sformatf("b2b_%0d_par_bit", f), 32'(par_bit), 32'(exp_b[f]));
            check($sformatf("b2b_%0d_ready", f), 32'(ready), 32'd1);
            if (f > 0) begin
                check($sformatf("b2b_%0d_spacing", f), 32'(cyc - last_cyc), 32'd5);
            end
            last_cyc = cyc;
            if (f < 2) begin
                P_DATA = words[f + 1];
            end else begin
                Data_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_idle_after", 32'(par_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
